// File: rtl/data_memory_ctrl.sv
// Data memory for the MEM stage. Handles RV32 byte/half/word loads and stores,
// a power-up clear sweep, and a UART debug port with a request/ack handshake.
module data_memory_ctrl #(
  parameter int DEPTH          = 1024,
  parameter int DBG_ADDR_W     = 9,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [31:0]           address,
  input  logic [31:0]           write_data,
  input  logic [2:0]            funct3,
  input  logic                  MemWrite,
  input  logic                  MemRead,
  input  logic                  enable,
  output logic [31:0]           read_data,
  output logic                  rd_valid,
  output logic                  misalign_err,
  output logic                  mem_ready,
  input  logic                  dbg_req,
  input  logic                  dbg_rw,
  input  logic [DBG_ADDR_W-1:0] dbg_addr,
  input  logic [31:0]           dbg_wdata,
  output logic                  dbg_ack,
  output logic [41:0]           tx_data,
  output logic                  tx_valid,
  input  logic                  tx_ready,
  output logic [31:0]           data_mem0
);

  localparam int ADDR_BITS = $clog2(DEPTH);

  typedef enum logic [1:0] {CLEAR, IDLE, DRD, DTX} state_t;

  state_t                state;
  logic [31:0]           mem [DEPTH];
  logic [ADDR_BITS-1:0]  clr_idx;
  logic [ADDR_BITS-1:0]  cpu_idx;
  logic [ADDR_BITS-1:0]  dbg_idx;
  logic [ADDR_BITS-1:0]  dbg_idx_q;
  logic [DBG_ADDR_W-1:0] dbg_addr_q;
  logic [ADDR_BITS-1:0]  wr_idx;
  logic [3:0]            wr_be;
  logic [31:0]           wr_data;
  logic                  active;
  logic                  st_mis;
  logic                  ld_mis;
  logic                  st_ok;
  logic                  ld_ok;
  logic                  dbg_accept;
  logic                  unused_addr_bits;

  // Upper address bits alias onto the same words.
  assign unused_addr_bits = ^address[31:ADDR_BITS+2];

  assign active    = (state != CLEAR);
  assign cpu_idx   = address[ADDR_BITS+1:2];
  assign dbg_idx   = ADDR_BITS'(dbg_addr);
  assign dbg_idx_q = ADDR_BITS'(dbg_addr_q);
  assign data_mem0 = mem[0];

  assign st_mis = MemWrite && ((funct3 == 3'b001 && address[0]) ||
                               (funct3 == 3'b010 && address[1:0] != 2'b00));
  assign ld_mis = MemRead && ((funct3[1:0] == 2'b01 && address[0]) ||
                              (funct3 == 3'b010 && address[1:0] != 2'b00));
  assign st_ok  = active && MemWrite && !st_mis && !funct3[2] && funct3[1:0] != 2'b11;
  assign ld_ok  = active && MemRead && !ld_mis;

  // The CPU always wins; the debug port only gets a fully idle cycle.
  assign dbg_accept = (state == IDLE) && dbg_req && !dbg_ack && !enable &&
                      !MemRead && !MemWrite;

  function automatic logic [31:0] load_extend(input logic [31:0] word,
                                              input logic [1:0]  off,
                                              input logic [2:0]  f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = word[{off, 3'b000} +: 8];
    h = off[1] ? word[31:16] : word[15:0];
    case (f3)
      3'b000:  return {{24{b[7]}}, b};
      3'b100:  return {24'h0, b};
      3'b001:  return {{16{h[15]}}, h};
      3'b101:  return {16'h0, h};
      default: return word;
    endcase
  endfunction

  always_comb begin
    wr_be   = 4'b0000;
    wr_data = 32'h0;
    wr_idx  = '0;
    if (state == CLEAR) begin
      wr_be  = 4'b1111;
      wr_idx = clr_idx;
    end else if (st_ok) begin
      wr_idx = cpu_idx;
      case (funct3)
        3'b000: begin
          wr_be   = 4'b0001 << address[1:0];
          wr_data = {4{write_data[7:0]}};
        end
        3'b001: begin
          wr_be   = address[1] ? 4'b1100 : 4'b0011;
          wr_data = {2{write_data[15:0]}};
        end
        default: begin
          wr_be   = 4'b1111;
          wr_data = write_data;
        end
      endcase
    end else if (dbg_accept && dbg_rw) begin
      wr_be   = 4'b1111;
      wr_idx  = dbg_idx;
      wr_data = dbg_wdata;
    end
  end

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (wr_be[i]) mem[wr_idx][8*i +: 8] <= wr_data[8*i +: 8];
    end
  end

  // Loads read the array before this edge's store lands (read-before-write).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= CLEAR_ON_RESET ? CLEAR : IDLE;
      mem_ready    <= !CLEAR_ON_RESET;
      clr_idx      <= '0;
      read_data    <= 32'h0;
      rd_valid     <= 1'b0;
      misalign_err <= 1'b0;
      dbg_ack      <= 1'b0;
      dbg_addr_q   <= '0;
      tx_data      <= 42'h0;
      tx_valid     <= 1'b0;
    end else begin
      dbg_ack      <= 1'b0;
      rd_valid     <= ld_ok;
      misalign_err <= active && (st_mis || ld_mis);
      if (ld_ok) read_data <= load_extend(mem[cpu_idx], address[1:0], funct3);
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + ADDR_BITS'(1);
          if (clr_idx == ADDR_BITS'(DEPTH - 1)) begin
            state     <= IDLE;
            mem_ready <= 1'b1;
          end
        end
        IDLE: begin
          if (dbg_accept) begin
            dbg_ack    <= 1'b1;
            dbg_addr_q <= dbg_addr;
            if (!dbg_rw) state <= DRD;
          end
        end
        DRD: begin
          tx_data  <= {1'b0, 9'(dbg_addr_q), mem[dbg_idx_q]};
          tx_valid <= 1'b1;
          state    <= DTX;
        end
        DTX: begin
          if (tx_ready) begin
            tx_valid <= 1'b0;
            state    <= IDLE;
          end
        end
      endcase
    end
  end

endmodule
